// File: rtl/seq_counter_ctrl.sv
// -----------------------------------------------------------------------------
// seq_counter_ctrl
//
// Run controller for the 8-bit sequence counter
// (0 -> 7 -> 1 -> 3 -> 2 -> 5 -> 11 -> 13 -> 7 ...). Each state can take an
// optional skip.
//
// A run command (laps + skip mask) is accepted through a valid/ready handshake.
// The controller then does the following:
//   - starts the counter;
//   - drives the counter's skip input from the mask;
//   - counts laps, ending each lap on 13;
//   - checks every observed transition against the counter model.
// A run finishes in the FINISH state. That state lasts one cycle. It pulses
// done and cnt_clr, and it latches a completion status.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active-high
//   cmd_valid_i      command request
//   cmd_ready_o      high in IDLE only
//   cmd_laps_i       laps to run (0 finishes immediately)
//   cmd_skip_mask_i  skip enable per state: bit0->7 bit1->1 bit2->3 bit3->2 bit4->5
//   abort_i          terminate the run in progress
//   count_in_i       counter's count_out
//   start_o          counter start (ARM while the counter shows 0)
//   skip_o           counter skip (ARM/RUN, mask bit of the current count)
//   cnt_clr_o        one-cycle counter clear, registered
//   busy_o           high in ARM or RUN
//   done_o           one-cycle completion pulse
//   status_o         00 ok, 01 aborted, 10 sequence error, 11 arm timeout
//   lap_count_o      laps completed in the current or last run
// -----------------------------------------------------------------------------
module seq_counter_ctrl #(
  parameter int unsigned ARM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] cmd_laps_i,
  input  logic [4:0] cmd_skip_mask_i,
  input  logic       abort_i,
  input  logic [7:0] count_in_i,
  output logic       start_o,
  output logic       skip_o,
  output logic       cnt_clr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] status_o,
  output logic [7:0] lap_count_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [7:0] ARM_TIMEOUT_V = 8'(ARM_TIMEOUT);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;
  localparam logic [1:0] ST_SEQ   = 2'b10;
  localparam logic [1:0] ST_TMO   = 2'b11;

  state_t     state_q;
  logic [7:0] laps_q;
  logic [4:0] mask_q;
  logic [7:0] lap_q;
  logic [7:0] timer_q;
  logic [7:0] prev_cnt_q;
  logic       prev_skip_q;
  logic [1:0] status_q;
  logic       done_q;
  logic       clr_q;

  logic       mask_bit;
  logic [7:0] exp_cnt;
  logic       seq_ok;
  logic [7:0] timer_d;
  logic [7:0] lap_d;

  // Expected counter value after one edge, given the previous value and the
  // skip that was applied to it. In RUN the counter never sits at 0, so the
  // start-dependent 0 -> 7 step is not needed here.
  function automatic logic [7:0] next_cnt(input logic [7:0] cnt, input logic skp);
    logic [7:0] nxt;
    case (cnt)
      8'd7:    nxt = skp ? 8'd3  : 8'd1;
      8'd1:    nxt = skp ? 8'd2  : 8'd3;
      8'd3:    nxt = skp ? 8'd5  : 8'd2;
      8'd2:    nxt = skp ? 8'd11 : 8'd5;
      8'd5:    nxt = skp ? 8'd13 : 8'd11;
      8'd11:   nxt = 8'd13;
      8'd13:   nxt = 8'd7;
      default: nxt = 8'd0;
    endcase
    return nxt;
  endfunction

  // Select the mask bit for the value currently shown by the counter.
  // The values 0, 11 and 13, and any illegal value, never skip.
  always_comb begin
    mask_bit = 1'b0;
    case (count_in_i)
      8'd7:    mask_bit = mask_q[0];
      8'd1:    mask_bit = mask_q[1];
      8'd3:    mask_bit = mask_q[2];
      8'd2:    mask_bit = mask_q[3];
      8'd5:    mask_bit = mask_q[4];
      default: mask_bit = 1'b0;
    endcase
  end

  assign skip_o      = ((state_q == S_ARM) || (state_q == S_RUN)) && mask_bit;
  assign start_o     = (state_q == S_ARM) && (count_in_i == 8'd0);
  assign busy_o      = (state_q == S_ARM) || (state_q == S_RUN);
  assign cmd_ready_o = (state_q == S_IDLE);
  assign cnt_clr_o   = clr_q;
  assign done_o      = done_q;
  assign status_o    = status_q;
  assign lap_count_o = lap_q;

  assign exp_cnt = next_cnt(prev_cnt_q, prev_skip_q);
  assign seq_ok  = (count_in_i == exp_cnt);
  assign timer_d = timer_q + 8'd1;
  assign lap_d   = (lap_q == 8'hFF) ? lap_q : lap_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      laps_q      <= 8'd0;
      mask_q      <= 5'd0;
      lap_q       <= 8'd0;
      timer_q     <= 8'd0;
      prev_cnt_q  <= 8'd0;
      prev_skip_q <= 1'b0;
      status_q    <= ST_OK;
      done_q      <= 1'b0;
      clr_q       <= 1'b0;
    end else begin
      // done/cnt_clr are high only for the single FINISH cycle.
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            laps_q  <= cmd_laps_i;
            mask_q  <= cmd_skip_mask_i;
            lap_q   <= 8'd0;
            timer_q <= 8'd0;
            if (cmd_laps_i == 8'd0) begin
              state_q  <= S_FINISH;
              status_q <= ST_OK;
              done_q   <= 1'b1;
              clr_q    <= 1'b1;
            end else begin
              state_q <= S_ARM;
            end
          end
        end

        S_ARM: begin
          // Timeout outranks abort. A counter that reaches 7 never times out.
          if ((count_in_i != 8'd7) && (timer_d == ARM_TIMEOUT_V)) begin
            state_q  <= S_FINISH;
            status_q <= ST_TMO;
            done_q   <= 1'b1;
            clr_q    <= 1'b1;
          end else if (abort_i) begin
            state_q  <= S_FINISH;
            status_q <= ST_ABORT;
            done_q   <= 1'b1;
            clr_q    <= 1'b1;
          end else if (count_in_i == 8'd7) begin
            state_q     <= S_RUN;
            prev_cnt_q  <= count_in_i;
            prev_skip_q <= skip_o;
          end else begin
            timer_q <= timer_d;
          end
        end

        S_RUN: begin
          if (!seq_ok) begin
            // A sequence error outranks an abort in the same cycle.
            state_q  <= S_FINISH;
            status_q <= ST_SEQ;
            done_q   <= 1'b1;
            clr_q    <= 1'b1;
          end else begin
            prev_cnt_q  <= count_in_i;
            prev_skip_q <= skip_o;
            if (count_in_i == 8'd13) begin
              lap_q <= lap_d;
            end
            if (abort_i) begin
              state_q  <= S_FINISH;
              status_q <= ST_ABORT;
              done_q   <= 1'b1;
              clr_q    <= 1'b1;
            end else if ((count_in_i == 8'd13) && (lap_d == laps_q)) begin
              state_q  <= S_FINISH;
              status_q <= ST_OK;
              done_q   <= 1'b1;
              clr_q    <= 1'b1;
            end
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
